// File: rtl/stream_tx.sv
// stream_tx: packet-aware stream buffer with optional store-and-forward gating.
//
// Parameters
//   DATA_WIDTH  payload width in bits
//   DATA_DEPTH  buffer entries (power of two, >= 2)
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   s_data_i/s_last_i   upstream beat payload and end-of-packet marker
//   s_valid_i/s_ready_o upstream handshake (ready = buffer not full)
//   m_data_o/m_last_o   downstream beat, read combinationally from the head entry
//   m_valid_o/m_ready_i downstream handshake
//   level_o             number of stored beats
//   pkt_cnt_o           number of stored beats carrying last=1
//   ovf_o               sticky: a packet filled the buffer before its last beat
//
// Configuration
//   STREAM_TX_STORE_AND_FORWARD_EN defined: output held until a whole packet is
//   stored (or the buffer fills, which forces the packet out and sets ovf_o).
//   Undefined: cut-through, m_valid_o = !empty, ovf_o = 0.
module stream_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         s_data_i,
    input  logic                          s_last_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    output logic [DATA_WIDTH-1:0]         m_data_o,
    output logic                          m_last_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [$clog2(DATA_DEPTH):0]   level_o,
    output logic [$clog2(DATA_DEPTH):0]   pkt_cnt_o,
    output logic                          ovf_o
);
    localparam int AW = $clog2(DATA_DEPTH);

    logic [AW:0]         r_wptr;
    logic [AW:0]         r_rptr;
    logic [AW:0]         r_level;
    logic [AW:0]         r_pkt;
    logic [DATA_WIDTH:0] r_mem [DATA_DEPTH];

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [AW:0] w_pkt_nxt;
    logic [AW:0] w_level_nxt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_empty   = (r_wptr == r_rptr);
    assign s_ready_o = !w_full;
    assign w_push    = s_valid_i && !w_full;
    assign w_pop     = m_valid_o && m_ready_i;

    assign {m_last_o, m_data_o} = r_mem[r_rptr[AW-1:0]];

    assign w_level_nxt = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_pkt_nxt   = r_pkt + (AW+1)'(w_push && s_last_i) - (AW+1)'(w_pop && m_last_o);

    assign level_o   = r_level;
    assign pkt_cnt_o = r_pkt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_pkt   <= '0;
            for (int i = 0; i < DATA_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= {s_last_i, s_data_i};
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_level <= w_level_nxt;
            r_pkt   <= w_pkt_nxt;
        end
    end

`ifdef STREAM_TX_STORE_AND_FORWARD_EN
    typedef enum logic [1:0] {HOLD, SEND, FORCE} state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_ovf;
    logic   w_ovf_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HOLD;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ovf_set) r_ovf <= 1'b1;
        end
    end

    // A complete packet releases the output; a full buffer with no complete
    // packet cannot make progress, so it is forced out and flagged.
    always_comb begin
        w_state_nxt = r_state;
        m_valid_o   = 1'b0;
        w_ovf_set   = 1'b0;
        case (r_state)
            HOLD: begin
                if (r_pkt != '0) begin
                    w_state_nxt = SEND;
                end else if (w_full) begin
                    w_state_nxt = FORCE;
                    w_ovf_set   = 1'b1;
                end
            end
            SEND: begin
                m_valid_o = !w_empty;
                if (w_pop && m_last_o && (w_pkt_nxt == '0)) w_state_nxt = HOLD;
            end
            FORCE: begin
                m_valid_o = !w_empty;
                if (w_pop && m_last_o) w_state_nxt = (w_pkt_nxt != '0) ? SEND : HOLD;
            end
            default: w_state_nxt = HOLD;
        endcase
    end

    assign ovf_o = r_ovf;
`else
    assign m_valid_o = !w_empty;
    assign ovf_o     = 1'b0;
`endif

endmodule

// File: tb/tb_stream_tx.sv
// tb_stream_tx: directed table plus multi-cycle sequences for stream_tx.
module tb_stream_tx;
`ifdef STREAM_TX_STORE_AND_FORWARD_EN
    localparam bit SF = 1'b1;
`else
    localparam bit SF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data_i = '0;
    logic       s_last_i = 1'b0;
    logic       s_valid_i = 1'b0;
    logic       s_ready_o;
    logic [7:0] m_data_o;
    logic       m_last_o;
    logic       m_valid_o;
    logic       m_ready_i = 1'b0;
    logic [3:0] level_o;
    logic [3:0] pkt_cnt_o;
    logic       ovf_o;

    stream_tx #(.DATA_WIDTH(8), .DATA_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s_data_i), .s_last_i(s_last_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_last_o(m_last_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .level_o(level_o), .pkt_cnt_o(pkt_cnt_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       sl;
        logic       mr;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic [3:0] elv;
        logic [3:0] epk;
    } vec_t;

    vec_t       tv[6];
    int         total = 0;
    int         passed = 0;
    int         cyc = 0;
    logic [8:0] popq[$];
    int         popc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Records the beat handed downstream this cycle, then advances one cycle.
    task automatic step();
        if (m_valid_o && m_ready_i) begin
            popq.push_back({m_last_o, m_data_o});
            popc.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_valid_i = 1'b0;
        s_last_i = 1'b0;
        s_data_i = '0;
        m_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        popq.delete();
        popc.delete();
    endtask

    initial begin
        tv[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, !SF,  8'hA1, 1'b0, 4'd1, 4'd0};
        tv[1] = '{1'b1, 8'hB2, 1'b1, 1'b0, !SF,  8'hA1, 1'b0, 4'd2, 4'd1};
        tv[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 4'd2, 4'd1};
        tv[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b1, 4'd1, 4'd1};
        tv[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0};
        tv[5] = '{1'b1, 8'hC3, 1'b1, 1'b1, !SF,  8'hC3, 1'b1, 4'd1, 4'd1};

        // Reset state, sampled while reset is held.
        @(negedge clk);
        chk("rst_valid", m_valid_o, 0);
        chk("rst_data", m_data_o, 0);
        chk("rst_last", m_last_o, 0);
        chk("rst_ready", s_ready_o, 1);
        chk("rst_level", level_o, 0);
        chk("rst_pkt", pkt_cnt_o, 0);
        chk("rst_ovf", ovf_o, 0);

        // Table: inputs for one cycle, outputs checked after that edge.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            s_valid_i = tv[i].sv;
            s_data_i  = tv[i].sd;
            s_last_i  = tv[i].sl;
            m_ready_i = tv[i].mr;
            step();
            chk($sformatf("v%0d_valid", i), m_valid_o, tv[i].ev);
            chk($sformatf("v%0d_data", i), m_data_o, tv[i].ed);
            chk($sformatf("v%0d_last", i), m_last_o, tv[i].el);
            chk($sformatf("v%0d_level", i), level_o, tv[i].elv);
            chk($sformatf("v%0d_pkt", i), pkt_cnt_o, tv[i].epk);
            chk($sformatf("v%0d_ready", i), s_ready_o, 1);
        end

        // Three-beat packet, downstream always ready.
        do_reset();
        m_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = 8'(8'h11 * (i + 1));
            s_last_i  = (i == 2);
            if (SF) chk($sformatf("pk3_hold%0d", i), m_valid_o, 0);
            step();
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        for (int t = 0; t < 20 && popq.size() < 3; t++) step();
        chk("pk3_count", popq.size(), 3);
        if (popq.size() == 3) begin
            chk("pk3_b0", popq[0], {1'b0, 8'h11});
            chk("pk3_b1", popq[1], {1'b0, 8'h22});
            chk("pk3_b2", popq[2], {1'b1, 8'h33});
            chk("pk3_consec", popc[2] - popc[0], 2);
        end

        // Fill with non-last beats while stalled, then pop/push while full.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = 8'(8'h80 + i);
            s_last_i  = 1'b0;
            step();
        end
        s_valid_i = 1'b0;
        step();
        chk("full_ready", s_ready_o, 0);
        chk("full_level", level_o, 8);
        chk("full_ovf", ovf_o, SF);
        chk("full_valid", m_valid_o, 1);
        chk("full_data", m_data_o, 8'h80);
        s_valid_i = 1'b1;
        s_data_i  = 8'hEE;
        m_ready_i = 1'b1;
        step();
        chk("fpp_level7", level_o, 7);
        chk("fpp_ready", s_ready_o, 1);
        m_ready_i = 1'b0;
        step();
        chk("fpp_level8", level_o, 8);
        s_valid_i = 1'b0;
        m_ready_i = 1'b1;
        for (int t = 0; t < 30 && popq.size() < 9; t++) step();
        chk("fpp_count", popq.size(), 9);
        if (popq.size() == 9) begin
            for (int i = 0; i < 8; i++) chk($sformatf("fpp_b%0d", i), popq[i], {1'b0, 8'(8'h80 + i)});
            chk("fpp_bEE", popq[8], {1'b0, 8'hEE});
        end
        chk("fpp_ovf_sticky", ovf_o, SF);

        // Twenty one-beat packets with random downstream backpressure.
        do_reset();
        begin
            int sent = 0;
            int maxlv = 0;
            for (int t = 0; t < 500 && (sent < 20 || popq.size() < 20); t++) begin
                m_ready_i = (sent < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
                s_valid_i = (sent < 20);
                s_data_i  = 8'(sent + 1);
                s_last_i  = 1'b1;
                if (s_valid_i && s_ready_o) sent++;
                step();
                if (int'(level_o) > maxlv) maxlv = int'(level_o);
            end
            s_valid_i = 1'b0;
            chk("rnd_count", popq.size(), 20);
            chk("rnd_maxlevel_ok", maxlv <= 8, 1);
            for (int i = 0; i < 20 && i < popq.size(); i++) chk($sformatf("rnd_b%0d", i), popq[i], {1'b1, 8'(i + 1)});
            chk("rnd_pkt_end", pkt_cnt_o, 0);
            chk("rnd_level_end", level_o, 0);
        end

        // Reset in the middle of a packet.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = 8'(8'hA1 + i);
            s_last_i  = 1'b0;
            step();
        end
        s_valid_i = 1'b0;
        chk("mid_level_pre", level_o, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_level", level_o, 0);
        chk("mid_valid", m_valid_o, 0);
        chk("mid_ovf", ovf_o, 0);
        chk("mid_data", m_data_o, 0);
        step();
        rst_n = 1'b1;
        m_ready_i = 1'b1;
        popq.delete();
        for (int t = 0; t < 5; t++) step();
        chk("mid_nopop", popq.size(), 0);
        chk("mid_level_after", level_o, 0);

        // Single beat without last, pushed on the first edge after release.
        do_reset();
        s_valid_i = 1'b1;
        s_data_i  = 8'h5A;
        s_last_i  = 1'b0;
        step();
        s_valid_i = 1'b0;
        chk("one_level", level_o, 1);
        chk("one_valid", m_valid_o, !SF);
        chk("one_data", m_data_o, 8'h5A);
        chk("one_pkt", pkt_cnt_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/stream_tx.md
STREAM_TX -- requirements
Module: stream_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, which sets the payload width in bits.
REQ-002 The block SHALL have parameter DATA_DEPTH, default 8, which sets the number of buffer entries; it must be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port s_data_i, input, DATA_WIDTH bits: the upstream beat payload.
REQ-006 The block SHALL have port s_last_i, input, 1 bit: marks the final beat of a packet.
REQ-007 The block SHALL have port s_valid_i, input, 1 bit: upstream beat valid.
REQ-008 The block SHALL have port s_ready_o, output, 1 bit: the block can accept a beat.
REQ-009 The block SHALL have port m_data_o, output, DATA_WIDTH bits: the downstream beat payload.
REQ-010 The block SHALL have port m_last_o, output, 1 bit: downstream packet end.
REQ-011 The block SHALL have port m_valid_o, output, 1 bit: downstream beat valid.
REQ-012 The block SHALL have port m_ready_i, input, 1 bit: downstream accepts the beat.
REQ-013 The block SHALL have port level_o, output, $clog2(DATA_DEPTH)+1 bits: the number of stored beats.
REQ-014 The block SHALL have port pkt_cnt_o, output, $clog2(DATA_DEPTH)+1 bits: the number of stored beats with last=1.
REQ-015 The block SHALL have port ovf_o, output, 1 bit: sticky flag for a packet longer than the buffer.

Function
REQ-016 Storage SHALL be a circular buffer of DATA_DEPTH entries of {last, data}, with read/write pointers one bit wider than the address; the pointers wrap naturally.
REQ-017 s_ready_o SHALL equal !full, where full means the address bits are equal and the pointer MSBs differ.
REQ-018 A push SHALL occur when s_valid_i & s_ready_o; it writes {s_last_i, s_data_i} at the write pointer, and the write pointer then increments by 1.
REQ-019 A pop SHALL occur when m_valid_o & m_ready_i; the read pointer then increments by 1.
REQ-020 m_data_o and m_last_o SHALL be driven combinationally from the entry at the read pointer.
REQ-021 The latency from a push into an empty buffer to m_valid_o=1 SHALL be 1 cycle.
REQ-022 level_o SHALL increment on push-only, decrement on pop-only, and stay unchanged on a simultaneous push and pop.
REQ-023 pkt_cnt_o SHALL increment on a push with s_last_i=1 and decrement on a pop with m_last_o=1; both in the same cycle leave it unchanged.
REQ-024 The FSM SHALL have the states HOLD (the reset state), SEND and FORCE.
REQ-025 HOLD -> SEND SHALL occur when pkt_cnt_o != 0; m_valid_o is 0 in HOLD.
REQ-026 In SEND, m_valid_o SHALL equal !empty; a pop with m_last_o=1 goes to HOLD if the next pkt_cnt is 0, else stays in SEND.
REQ-027 HOLD -> FORCE SHALL occur when the buffer is full and pkt_cnt_o=0; this also sets ovf_o=1.
REQ-028 In FORCE, m_valid_o SHALL equal !empty, independent of pkt_cnt; a pop with m_last_o=1 goes to HOLD, or to SEND if the next pkt_cnt != 0.
REQ-029 m_valid_o, m_data_o and m_last_o SHALL stay stable while m_valid_o=1 and m_ready_i=0.
REQ-030 When full, a push SHALL NOT occur, even if a pop occurs in the same cycle; the beat is accepted in the next cycle.
REQ-031 The block SHALL NOT pop when empty.
REQ-032 ovf_o SHALL clear only on reset.

Reset
REQ-033 Assertion of rst_n=0 SHALL immediately, asynchronously, clear the pointers, level_o, pkt_cnt_o, ovf_o and memory, and set the FSM to HOLD.
REQ-034 Under reset, the outputs SHALL be m_valid_o=0, m_data_o=0, m_last_o=0 and s_ready_o=1.
REQ-035 A reset mid-packet SHALL discard all stored beats; no partial packet is emitted after release.
REQ-036 The first push SHALL be accepted on the first rising edge after rst_n=1.

Configuration
REQ-037 The macro STREAM_TX_STORE_AND_FORWARD_EN SHALL select between two behaviours.
- Defined: the FSM operates as in REQ-024..REQ-028.
- Undefined: the FSM is absent and the block operates as cut-through. In that mode m_valid_o = !empty, ovf_o is tied to 0, and pkt_cnt_o is still maintained.

Verification
REQ-038 Bench scenario (macro defined, m_ready_i=1): push 3 beats 0x11, 0x22, 0x33(last) -> m_valid_o stays 0 until the cycle after 0x33 is pushed; the bench then sees 0x11, 0x22, 0x33 on consecutive cycles with m_last_o=1 only on 0x33.
REQ-039 Bench scenario (DATA_DEPTH=8): push 8 non-last beats with m_ready_i=0 -> s_ready_o=0, level_o=8, FSM enters FORCE, ovf_o=1, and m_valid_o=1 with m_data_o equal to the first beat.
REQ-040 Bench scenario: run 20 beats of 1-beat packets with random m_ready_i -> output order matches input order, pointers wrap, level_o never exceeds 8, and pkt_cnt_o ends at 0.
REQ-041 Bench scenario: while full, assert s_valid_i=1 and m_ready_i=1 in the same cycle -> the pop happens, the push is refused that cycle, and level_o goes 8 -> 7 -> 8.
REQ-042 Bench scenario: assert rst_n=0 after 2 beats of a 4-beat packet -> level_o=0, m_valid_o=0 and ovf_o=0 immediately; no beat from before reset appears at the output.
REQ-043 Bench scenario (macro undefined): push 0x5A(no last) -> m_valid_o=1 one cycle later with m_data_o=0x5A.
